correlator_lag: RTL and testbench

CORRELATOR_LAG -- requirements
Module: correlator_lag

---
 rtl/correlator_lag.sv | 187 ++++++++++++++++++
 tb/tb_correlator_lag.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/correlator_lag.sv
// Multi-channel 1-bit lag correlator: per-channel ones counts and per-pair XNOR counts
// over lags 0..MAX_LAG, snapshotted every integ_len samples and streamed as bytes.
//
// state | meaning
// IDLE  | waiting for a snapshot
// HDR   | sending sync byte 0xA5
// FNO   | sending captured frame number
// DATA  | sending counter words, MSB byte first
module correlator_lag #(
    parameter int NUM_INPUTS = 10,
    parameter int RESOLUTION = 12,
    parameter int MAX_LAG    = 3,
    parameter int INTEG_BITS = 16
) (
    input  logic                  clki,
    input  logic                  rstn,
    input  logic [NUM_INPUTS-1:0] in,
    input  logic                  sample_en,
    input  logic                  enable,
    input  logic [INTEG_BITS-1:0] integ_len,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  overrun
);

    localparam int NUM_PAIRS = NUM_INPUTS * (NUM_INPUTS - 1) / 2;
    localparam int NUM_WORDS = NUM_INPUTS + NUM_PAIRS * (MAX_LAG + 1);
    localparam int BPW       = (RESOLUTION + 7) / 8;
    localparam int WIDX_W    = $clog2(NUM_WORDS);
    localparam int BIDX_W    = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [RESOLUTION-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {IDLE, HDR, FNO, DATA} state_t;

    state_t                  state_q, state_d;
    logic                    run;
    logic                    sample_ev;
    logic                    snap;
    logic [INTEG_BITS-1:0]   samp_cnt;
    logic [INTEG_BITS:0]     samp_next;
    logic [NUM_INPUTS-1:0]   tap [MAX_LAG+1];
    logic [NUM_WORDS-1:0]    hit;
    logic [RESOLUTION-1:0]   cnt    [NUM_WORDS];
    logic [RESOLUTION-1:0]   shadow [NUM_WORDS];
    logic [7:0]              frame_no;
    logic [7:0]              fno_cap;
    logic [WIDX_W-1:0]       widx;
    logic [BIDX_W-1:0]       bidx;
    logic                    last_byte;
    logic                    last_word;
    logic [BPW*8-1:0]        word_ext;

    function automatic int pair_index(input int i, input int j);
        return i * (2 * NUM_INPUTS - i - 1) / 2 + (j - i - 1);
    endfunction

    function automatic logic [RESOLUTION-1:0] bump(input logic [RESOLUTION-1:0] v, input logic h);
        return (h && (v != CNT_MAX)) ? v + RESOLUTION'(1) : v;
    endfunction

    // run holds off sampling on the first edge after reset release
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) run <= 1'b0;
        else       run <= 1'b1;
    end

    assign sample_ev = sample_en & enable & (integ_len != '0) & run;
    assign samp_next = {1'b0, samp_cnt} + (INTEG_BITS+1)'(1);
    assign snap      = sample_ev & (samp_next >= {1'b0, integ_len});

    generate
        if (MAX_LAG > 0) begin : g_hist
            logic [NUM_INPUTS-1:0] hist [MAX_LAG];

            always_ff @(posedge clki or negedge rstn) begin
                if (!rstn) begin
                    for (int k = 0; k < MAX_LAG; k++) hist[k] <= '0;
                end else if (!enable) begin
                    for (int k = 0; k < MAX_LAG; k++) hist[k] <= '0;
                end else if (sample_ev) begin
                    hist[0] <= in;
                    for (int k = 1; k < MAX_LAG; k++) hist[k] <= hist[k-1];
                end
            end

            always_comb begin
                tap[0] = in;
                for (int k = 1; k <= MAX_LAG; k++) tap[k] = hist[k-1];
            end
        end else begin : g_nohist
            always_comb tap[0] = in;
        end
    endgenerate

    // hit bits follow stream order: channels, then pairs (i,j) with lags 0..MAX_LAG
    always_comb begin
        hit = '0;
        for (int c = 0; c < NUM_INPUTS; c++) hit[c] = in[c];
        for (int i = 0; i < NUM_INPUTS - 1; i++)
            for (int j = i + 1; j < NUM_INPUTS; j++)
                for (int k = 0; k <= MAX_LAG; k++)
                    hit[NUM_INPUTS + pair_index(i, j) * (MAX_LAG + 1) + k] = ~(in[i] ^ tap[k][j]);
    end

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            samp_cnt <= '0;
            for (int w = 0; w < NUM_WORDS; w++) cnt[w] <= '0;
        end else if (!enable) begin
            samp_cnt <= '0;
            for (int w = 0; w < NUM_WORDS; w++) cnt[w] <= '0;
        end else if (sample_ev) begin
            samp_cnt <= snap ? '0 : samp_next[INTEG_BITS-1:0];
            for (int w = 0; w < NUM_WORDS; w++)
                cnt[w] <= snap ? '0 : bump(cnt[w], hit[w]);
        end
    end

    // a snapshot landing mid-stream is dropped, but frame numbering still advances
    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            frame_no <= 8'h00;
            fno_cap  <= 8'h00;
            overrun  <= 1'b0;
            for (int w = 0; w < NUM_WORDS; w++) shadow[w] <= '0;
        end else if (snap) begin
            frame_no <= frame_no + 8'd1;
            if (state_q == IDLE) begin
                fno_cap <= frame_no;
                for (int w = 0; w < NUM_WORDS; w++) shadow[w] <= bump(cnt[w], hit[w]);
            end else begin
                overrun <= 1'b1;
            end
        end
    end

    assign last_byte = (bidx == BIDX_W'(BPW - 1));
    assign last_word = (widx == WIDX_W'(NUM_WORDS - 1));

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (snap) state_d = HDR;
            HDR:     if (out_ready) state_d = FNO;
            FNO:     if (out_ready) state_d = DATA;
            DATA:    if (out_ready && last_byte && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clki or negedge rstn) begin
        if (!rstn) begin
            widx <= '0;
            bidx <= '0;
        end else if (state_q == DATA && out_ready) begin
            if (last_byte) begin
                bidx <= '0;
                widx <= last_word ? '0 : widx + WIDX_W'(1);
            end else begin
                bidx <= bidx + BIDX_W'(1);
            end
        end
    end

    always_comb begin
        word_ext = '0;
        word_ext[RESOLUTION-1:0] = shadow[widx];
        out_data = 8'h00;
        case (state_q)
            HDR:     out_data = 8'hA5;
            FNO:     out_data = fno_cap;
            DATA:    out_data = word_ext[(BPW - 1 - int'(bidx)) * 8 +: 8];
            default: out_data = 8'h00;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = busy;

endmodule

// File: tb/tb_correlator_lag.sv
// Bench for correlator_lag (3 channels, 12-bit counters, lag 1) against a
// frame-level model that recounts each frame from the list of samples it contained.
module tb_correlator_lag;

    localparam int N      = 3;
    localparam int RES    = 12;
    localparam int LAG    = 1;
    localparam int IB     = 16;
    localparam int BPW    = 2;
    localparam int NW     = N + N * (N - 1) / 2 * (LAG + 1);
    localparam int FLEN   = 2 + NW * BPW;
    localparam int SATMAX = (1 << RES) - 1;

    logic          clki = 1'b0;
    logic          rstn = 1'b0;
    logic [N-1:0]  din = '0;
    logic          sample_en = 1'b0;
    logic          enable = 1'b0;
    logic [IB-1:0] integ_len = '0;
    logic [7:0]    out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          overrun;

    correlator_lag #(.NUM_INPUTS(N), .RESOLUTION(RES), .MAX_LAG(LAG), .INTEG_BITS(IB)) dut (
        .clki(clki), .rstn(rstn), .in(din), .sample_en(sample_en), .enable(enable),
        .integ_len(integ_len), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .overrun(overrun)
    );

    always #5 clki = ~clki;

    int total = 0;
    int bad = 0;

    logic [7:0]   got[$];
    int           got_cycles;
    int           unstable;
    bit           timed_out;

    logic [N-1:0] m_hist[$];
    logic [N-1:0] m_fcur[$];
    logic [N-1:0] m_fprev[$];
    int           m_scount;
    int           m_fno;
    bit           m_snap;
    logic [7:0]   exp_frame[$];

    task automatic push_word(input int c);
        int w;
        w = (c > SATMAX) ? SATMAX : c;
        exp_frame.push_back(8'((w >> 8) & 255));
        exp_frame.push_back(8'(w & 255));
    endtask

    task automatic build_frame();
        int c;
        logic b;
        exp_frame.delete();
        exp_frame.push_back(8'hA5);
        exp_frame.push_back(8'(m_fno));
        for (int ch = 0; ch < N; ch++) begin
            c = 0;
            foreach (m_fcur[t]) if (m_fcur[t][ch]) c++;
            push_word(c);
        end
        for (int i = 0; i < N - 1; i++)
            for (int j = i + 1; j < N; j++)
                for (int k = 0; k <= LAG; k++) begin
                    c = 0;
                    foreach (m_fcur[t]) begin
                        b = (k == 0) ? m_fcur[t][j] : m_fprev[t][j];
                        if (m_fcur[t][i] == b) c++;
                    end
                    push_word(c);
                end
    endtask

    task automatic model_clear();
        m_hist.delete();
        m_fcur.delete();
        m_fprev.delete();
        m_scount = 0;
    endtask

    task automatic model_sample(input logic [N-1:0] v);
        logic [N-1:0] prev;
        if (!enable || integ_len == 0) return;
        prev = (m_hist.size() > 0) ? m_hist[m_hist.size()-1] : '0;
        m_fcur.push_back(v);
        m_fprev.push_back(prev);
        m_hist.push_back(v);
        if (m_hist.size() > LAG) void'(m_hist.pop_front());
        m_scount++;
        if (m_scount >= int'(integ_len)) begin
            build_frame();
            m_fno = (m_fno + 1) % 256;
            m_fcur.delete();
            m_fprev.delete();
            m_scount = 0;
            m_snap = 1;
        end
    endtask

    task automatic do_sample(input logic [N-1:0] v);
        din = v;
        sample_en = 1'b1;
        model_sample(v);
        @(posedge clki); #1;
        sample_en = 1'b0;
    endtask

    task automatic idle_cycle();
        sample_en = 1'b0;
        @(posedge clki); #1;
    endtask

    task automatic enable_pulse();
        enable = 1'b0;
        model_clear();
        @(posedge clki); #1;
        enable = 1'b1;
    endtask

    task automatic collect(input int n, input bit rnd);
        bit         stalled;
        logic [7:0] stall_data;
        got.delete();
        got_cycles = 0;
        unstable = 0;
        stalled = 0;
        stall_data = 8'h00;
        while (got.size() < n && got_cycles < 2000) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clki);
            if (stalled && (!out_valid || out_data !== stall_data)) unstable++;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                stalled = 0;
            end else if (out_valid) begin
                stalled = 1;
                stall_data = out_data;
            end
            @(posedge clki); #1;
            got_cycles++;
        end
        timed_out = (got.size() < n);
        out_ready = 1'b1;
    endtask

    function automatic int frame_diff(input logic [7:0] ref_q[$], output int first);
        int d;
        d = 0;
        first = -1;
        if (got.size() != ref_q.size()) begin
            first = 0;
            return 1 + ((got.size() > ref_q.size()) ? got.size() : ref_q.size());
        end
        foreach (ref_q[i]) if (got[i] !== ref_q[i]) begin
            if (first < 0) first = i;
            d++;
        end
        return d;
    endfunction

    task automatic test_reset();
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: valid=%b busy=%b overrun=%b data=%h want 0 0 0 00",
                     out_valid, busy, overrun, out_data);
        end
        @(posedge clki); #1;
        rstn = 1'b1;
        enable = 1'b1;
        model_clear();
        m_fno = 0;
        idle_cycle();
        idle_cycle();
    endtask

    task automatic test_basic();
        logic [7:0] ref_b[$] = '{8'hA5, 8'h00, 8'h00, 8'h04, 8'h00, 8'h04, 8'h00, 8'h04,
                                 8'h00, 8'h04, 8'h00, 8'h03, 8'h00, 8'h04, 8'h00, 8'h03,
                                 8'h00, 8'h04, 8'h00, 8'h03};
        int d, first;
        integ_len = 4;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) do_sample(3'b111);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_busy: busy=%b want 1", busy);
        end
        collect(FLEN, 0);
        d = frame_diff(ref_b, first);
        total++;
        if (timed_out || d != 0) begin
            bad++;
            $display("FAIL basic_frame: %0d bytes differ (first idx %0d), got %0d bytes want %0d",
                     d, first, got.size(), FLEN);
        end
        total++;
        if (got_cycles != FLEN) begin
            bad++;
            $display("FAIL basic_no_bubble: took %0d cycles want %0d", got_cycles, FLEN);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_idle_after: busy=%b want 0", busy);
        end
    endtask

    task automatic test_pattern();
        logic [N-1:0] pat[4] = '{3'b010, 3'b001, 3'b010, 3'b001};
        int d, first;
        integ_len = 4;
        enable_pulse();
        foreach (pat[i]) do_sample(pat[i]);
        collect(FLEN, 1);
        d = frame_diff(exp_frame, first);
        total++;
        if (timed_out || d != 0) begin
            bad++;
            $display("FAIL pattern_frame: %0d bytes differ (first idx %0d)", d, first);
        end
        total++;
        if (got.size() < 12 || {got[8], got[9]} !== 16'h0000 || {got[10], got[11]} !== 16'h0004) begin
            bad++;
            $display("FAIL pattern_pair01: lag0/lag1 bytes wrong, got size %0d want lag0=0000 lag1=0004",
                     got.size());
        end
        total++;
        if (unstable != 0) begin
            bad++;
            $display("FAIL pattern_hold: %0d stalled bytes changed, want 0", unstable);
        end
    endtask

    task automatic test_enable_drop();
        int d, first;
        integ_len = 4;
        do_sample(N'($urandom));
        do_sample(N'($urandom));
        enable_pulse();
        for (int i = 0; i < 4; i++) do_sample(N'($urandom));
        collect(FLEN, 1);
        d = frame_diff(exp_frame, first);
        total++;
        if (timed_out || d != 0) begin
            bad++;
            $display("FAIL enable_drop_frame: %0d bytes differ (first idx %0d)", d, first);
        end
    endtask

    task automatic test_len_change();
        int d, first;
        integ_len = 8;
        for (int i = 0; i < 5; i++) do_sample(N'($urandom));
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL len_change_early: busy=%b want 0", busy);
        end
        integ_len = 3;
        do_sample(N'($urandom));
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL len_change_snap: busy=%b want 1", busy);
        end
        collect(FLEN, 1);
        d = frame_diff(exp_frame, first);
        total++;
        if (timed_out || d != 0) begin
            bad++;
            $display("FAIL len_change_frame: %0d bytes differ (first idx %0d)", d, first);
        end
    endtask

    task automatic test_zero_len();
        int d, first;
        integ_len = 0;
        for (int i = 0; i < 10; i++) do_sample(N'($urandom));
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_len_idle: busy=%b want 0", busy);
        end
        integ_len = 2;
        do_sample(N'($urandom));
        do_sample(N'($urandom));
        collect(FLEN, 0);
        d = frame_diff(exp_frame, first);
        total++;
        if (timed_out || d != 0) begin
            bad++;
            $display("FAIL zero_len_frame: %0d bytes differ (first idx %0d)", d, first);
        end
    endtask

    task automatic test_random();
        int d, first, cyc, r;
        for (int f = 0; f < 12; f++) begin
            integ_len = IB'($urandom_range(1, 6));
            m_snap = 0;
            cyc = 0;
            while (!m_snap && cyc < 300) begin
                r = $urandom_range(0, 99);
                if (r < 65) begin
                    do_sample(N'($urandom));
                end else if (r < 80) begin
                    din = N'($urandom);
                    idle_cycle();
                end else if (r < 90) begin
                    enable_pulse();
                end else begin
                    integ_len = IB'($urandom_range(1, 6));
                end
                cyc++;
            end
            collect(FLEN, 1);
            d = frame_diff(exp_frame, first);
            total++;
            if (!m_snap || timed_out || d != 0) begin
                bad++;
                $display("FAIL random_frame_%0d: %0d bytes differ (first idx %0d) snap=%0d",
                         f, d, first, m_snap);
            end
            total++;
            if (unstable != 0) begin
                bad++;
                $display("FAIL random_hold_%0d: %0d stalled bytes changed, want 0", f, unstable);
            end
        end
    endtask

    task automatic test_saturation();
        int d, first, nsat;
        integ_len = 4200;
        for (int i = 0; i < 4200; i++) do_sample(3'b111);
        collect(FLEN, 0);
        d = frame_diff(exp_frame, first);
        total++;
        if (timed_out || d != 0) begin
            bad++;
            $display("FAIL sat_frame: %0d bytes differ (first idx %0d)", d, first);
        end
        nsat = 0;
        for (int i = 2; i + 1 < got.size(); i += 2)
            if ({got[i], got[i+1]} === 16'h0FFF) nsat++;
        total++;
        if (nsat != NW) begin
            bad++;
            $display("FAIL sat_words: %0d words at 0FFF, want %0d", nsat, NW);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_a[$];
        int d, first;
        rstn = 1'b0;
        #1;
        @(posedge clki); #1;
        rstn = 1'b1;
        model_clear();
        m_fno = 0;
        out_ready = 1'b0;
        integ_len = 4;
        idle_cycle();
        for (int i = 0; i < 4; i++) do_sample(3'b111);
        exp_a = exp_frame;
        for (int i = 0; i < 3; i++) idle_cycle();
        total++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            bad++;
            $display("FAIL overrun_hold_hdr: valid=%b data=%h want 1 A5", out_valid, out_data);
        end
        for (int i = 0; i < 4; i++) do_sample(N'($urandom));
        total++;
        if (overrun !== 1'b1 || out_data !== 8'hA5) begin
            bad++;
            $display("FAIL overrun_flag: overrun=%b data=%h want 1 A5", overrun, out_data);
        end
        collect(FLEN, 0);
        d = frame_diff(exp_a, first);
        total++;
        if (timed_out || d != 0 || got[1] !== 8'h00) begin
            bad++;
            $display("FAIL overrun_first_frame: %0d bytes differ (first idx %0d), fno want 00", d, first);
        end
        for (int i = 0; i < 4; i++) do_sample(N'($urandom));
        collect(FLEN, 0);
        d = frame_diff(exp_frame, first);
        total++;
        if (timed_out || d != 0 || got[1] !== 8'h02) begin
            bad++;
            $display("FAIL overrun_next_frame: %0d bytes differ (first idx %0d), fno want 02", d, first);
        end
    endtask

    task automatic test_midstream_reset();
        int d, first, w;
        out_ready = 1'b1;
        integ_len = 4;
        for (int i = 0; i < 4; i++) do_sample(N'($urandom));
        collect(7, 0);
        rstn = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 || out_data !== 8'h00) begin
            bad++;
            $display("FAIL midreset_outputs: valid=%b busy=%b overrun=%b data=%h want 0 0 0 00",
                     out_valid, busy, overrun, out_data);
        end
        model_clear();
        m_fno = 0;
        @(posedge clki); #1;
        rstn = 1'b1;
        din = 3'b111;
        sample_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clki); #1;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL first_edge_skip: busy=%b after 4 edges want 0", busy);
        end
        w = 0;
        while (!busy && w < 4) begin
            @(posedge clki); #1;
            w++;
        end
        sample_en = 1'b0;
        for (int i = 0; i < 4; i++) model_sample(3'b111);
        collect(FLEN, 0);
        d = frame_diff(exp_frame, first);
        total++;
        if (timed_out || d != 0 || got[1] !== 8'h00) begin
            bad++;
            $display("FAIL midreset_frame: %0d bytes differ (first idx %0d), fno want 00", d, first);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_pattern();
        test_enable_drop();
        test_len_change();
        test_zero_len();
        test_random();
        test_saturation();
        test_overrun();
        test_midstream_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
